// File: rtl/cardinal_nic.sv
// cardinal_nic: processor-side NIC responder bridging a node processor to its
// ring router through a one-entry input buffer and a one-entry output buffer.
// Packets are 64 bits, with the router's bit 0 as the most significant bit.
// Here that bit is index 63 of a [63:0] vector, so the VC bit is out_buf[63].
module cardinal_nic (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic [63:0] d_in,
  output logic [63:0] d_out,
  input  logic        nicEn,
  input  logic        nicWrEn,
  input  logic        net_si,
  output logic        net_ri,
  input  logic [63:0] net_di,
  output logic        net_so,
  input  logic        net_ro,
  output logic [63:0] net_do,
  input  logic        net_polarity
);

  localparam int unsigned PKT_W  = 64;
  localparam int unsigned VC_BIT = PKT_W - 1;

  localparam logic [1:0] ADDR_IN_BUF  = 2'b00;
  localparam logic [1:0] ADDR_IN_STAT = 2'b01;
  localparam logic [1:0] ADDR_OUT_BUF = 2'b10;
  localparam logic [1:0] ADDR_OUT_ST  = 2'b11;

  logic [PKT_W-1:0] in_buf;
  logic             in_full;
  logic [PKT_W-1:0] out_buf;
  logic             out_full;

  logic rd_en;
  logic wr_en;
  logic pop_in;
  logic accept_in;
  logic load_out;
  logic send;

  // Decode processor accesses and the two channel handshakes.
  always_comb begin
    rd_en     = nicEn & ~nicWrEn;
    wr_en     = nicEn & nicWrEn;
    pop_in    = rd_en & (addr == ADDR_IN_BUF);
    accept_in = net_si & ~in_full;
    load_out  = wr_en & (addr == ADDR_OUT_BUF) & ~out_full;
    send      = out_full & net_ro & (net_polarity == out_buf[VC_BIT]);
  end

  // Router-facing outputs; both follow the flags, so reset forces them at once.
  always_comb begin
    net_ri = ~in_full;
    net_so = send;
    net_do = out_full ? out_buf : '0;
  end

  // Processor read mux, zero-latency.
  always_comb begin
    d_out = '0;
    if (rd_en) begin
      case (addr)
        ADDR_IN_BUF:  d_out = in_buf;
        ADDR_IN_STAT: d_out = {(PKT_W-1)'(0), in_full};
        ADDR_OUT_BUF: d_out = out_buf;
        ADDR_OUT_ST:  d_out = {(PKT_W-1)'(0), out_full};
        default:      d_out = '0;
      endcase
    end
  end

  // Input channel: router fills, processor read of the data register drains.
  // A pop while empty is harmless; an accept in that cycle wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_buf  <= '0;
      in_full <= 1'b0;
    end else begin
      if (pop_in) begin
        in_full <= 1'b0;
      end
      if (accept_in) begin
        in_buf  <= net_di;
        in_full <= 1'b1;
      end
    end
  end

  // Output channel: processor fills when empty, a matching-polarity send drains.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_buf  <= '0;
      out_full <= 1'b0;
    end else begin
      if (load_out) begin
        out_buf  <= d_in;
        out_full <= 1'b1;
      end else if (send) begin
        out_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cardinal_nic.sv
// Bench for cardinal_nic: per-cycle vector table plus a send-side scoreboard
// and hand-written reset sequences.
module tb_cardinal_nic;

  logic        clk;
  logic        reset;
  logic [1:0]  addr;
  logic [63:0] d_in;
  logic [63:0] d_out;
  logic        nicEn;
  logic        nicWrEn;
  logic        net_si;
  logic        net_ri;
  logic [63:0] net_di;
  logic        net_so;
  logic        net_ro;
  logic [63:0] net_do;
  logic        net_polarity;

  int tests;
  int fails;

  logic [63:0] out_q[$];

  typedef struct {
    logic [1:0]  addr;
    logic        en;
    logic        wr;
    logic [63:0] din;
    logic        si;
    logic [63:0] di;
    logic        ro;
    logic        pol;
    logic        push;
    logic [63:0] e_dout;
    logic        e_so;
    logic        e_ri;
    logic [63:0] e_do;
  } vec_t;

  vec_t vq[$];

  localparam logic [63:0] Z  = 64'h0;
  localparam logic [63:0] P1 = 64'h0000_0000_DEAD_BEEF;
  localparam logic [63:0] P2 = 64'h8000_0000_0000_0001;
  localparam logic [63:0] PA = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] PB = 64'h8000_0000_0000_00B0;

  cardinal_nic dut (
    .clk          (clk),
    .reset        (reset),
    .addr         (addr),
    .d_in         (d_in),
    .d_out        (d_out),
    .nicEn        (nicEn),
    .nicWrEn      (nicWrEn),
    .net_si       (net_si),
    .net_ri       (net_ri),
    .net_di       (net_di),
    .net_so       (net_so),
    .net_ro       (net_ro),
    .net_do       (net_do),
    .net_polarity (net_polarity)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  task automatic add(input logic [1:0] a, input logic en, input logic wr, input logic [63:0] din,
                     input logic si, input logic [63:0] di, input logic ro, input logic pol,
                     input logic push, input logic [63:0] e_dout, input logic e_so,
                     input logic e_ri, input logic [63:0] e_do);
    vec_t v;
    v.addr = a; v.en = en; v.wr = wr; v.din = din; v.si = si; v.di = di;
    v.ro = ro; v.pol = pol; v.push = push;
    v.e_dout = e_dout; v.e_so = e_so; v.e_ri = e_ri; v.e_do = e_do;
    vq.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    addr = v.addr; nicEn = v.en; nicWrEn = v.wr; d_in = v.din;
    net_si = v.si; net_di = v.di; net_ro = v.ro; net_polarity = v.pol;
    if (v.push) out_q.push_back(v.din);
  endtask

  // Scoreboard: every packet the router sees must be the oldest one written.
  always @(negedge clk) begin
    if (reset && net_so) begin
      if (out_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected: got net_so=1 net_do=%h expected no send", net_do);
      end else begin
        chk("sb_net_do", net_do, out_q.pop_front());
      end
    end
  end

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b0;
    addr = '0; d_in = '0; nicEn = 1'b0; nicWrEn = 1'b0;
    net_si = 1'b0; net_di = '0; net_ro = 1'b0; net_polarity = 1'b0;

    // Reset held low with random inputs.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      addr = 2'($urandom); nicEn = 1'($urandom); nicWrEn = 1'($urandom);
      d_in = {$urandom, $urandom}; net_si = 1'($urandom); net_di = {$urandom, $urandom};
      net_ro = 1'($urandom); net_polarity = 1'($urandom);
      @(negedge clk);
      chk($sformatf("rst%0d d_out", i), d_out, Z);
      chk($sformatf("rst%0d net_so", i), 64'(net_so), Z);
      chk($sformatf("rst%0d net_ri", i), 64'(net_ri), 64'd1);
      chk($sformatf("rst%0d net_do", i), net_do, Z);
    end
    @(posedge clk); #1;
    addr = '0; nicEn = 1'b0; nicWrEn = 1'b0; d_in = '0;
    net_si = 1'b0; net_di = '0; net_ro = 1'b0; net_polarity = 1'b0;
    reset = 1'b1;

    //  addr en wr din        si di        ro pol push  e_dout     so ri e_do
    add(2'd1, 1, 0, Z,         0, Z,        0, 0, 0,   Z,         0, 1, Z);
    add(2'd3, 1, 0, Z,         0, Z,        0, 0, 0,   Z,         0, 1, Z);
    add(2'd2, 1, 1, P1,        0, Z,        1, 0, 1,   Z,         0, 1, Z);
    add(2'd0, 0, 0, Z,         0, Z,        1, 0, 0,   Z,         1, 1, P1);
    add(2'd3, 1, 0, Z,         0, Z,        1, 0, 0,   Z,         0, 1, Z);
    add(2'd2, 1, 1, P2,        0, Z,        1, 0, 1,   Z,         0, 1, Z);
    add(2'd3, 1, 0, Z,         0, Z,        1, 0, 0,   64'd1,     0, 1, P2);
    add(2'd0, 0, 0, Z,         0, Z,        1, 0, 0,   Z,         0, 1, P2);
    add(2'd0, 0, 0, Z,         0, Z,        1, 0, 0,   Z,         0, 1, P2);
    add(2'd3, 1, 0, Z,         0, Z,        1, 1, 0,   64'd1,     1, 1, P2);
    add(2'd3, 1, 0, Z,         0, Z,        1, 1, 0,   Z,         0, 1, Z);
    add(2'd0, 0, 0, Z,         1, 64'h1234, 0, 0, 0,   Z,         0, 1, Z);
    add(2'd1, 1, 0, Z,         0, Z,        0, 0, 0,   64'd1,     0, 0, Z);
    add(2'd0, 1, 0, Z,         0, Z,        0, 0, 0,   64'h1234,  0, 0, Z);
    add(2'd1, 1, 0, Z,         0, Z,        0, 0, 0,   Z,         0, 1, Z);
    add(2'd0, 1, 0, Z,         0, Z,        0, 0, 0,   64'h1234,  0, 1, Z);
    add(2'd2, 1, 1, PA,        0, Z,        0, 0, 1,   Z,         0, 1, Z);
    add(2'd2, 1, 1, 64'hFFFF,  0, Z,        0, 0, 0,   Z,         0, 1, PA);
    add(2'd2, 1, 0, Z,         0, Z,        0, 0, 0,   PA,        0, 1, PA);
    add(2'd0, 0, 0, Z,         1, 64'hAAAA, 0, 0, 0,   Z,         0, 1, PA);
    add(2'd1, 1, 0, Z,         1, 64'hBBBB, 0, 0, 0,   64'd1,     0, 0, PA);
    add(2'd0, 1, 0, Z,         1, 64'hBBBB, 0, 0, 0,   64'hAAAA,  0, 0, PA);
    add(2'd1, 1, 0, Z,         1, 64'hBBBB, 0, 0, 0,   Z,         0, 1, PA);
    add(2'd0, 1, 0, Z,         0, Z,        0, 0, 0,   64'hBBBB,  0, 0, PA);
    add(2'd2, 1, 1, 64'hCCCC,  0, Z,        1, 0, 0,   Z,         1, 1, PA);
    add(2'd3, 1, 0, Z,         0, Z,        1, 0, 0,   Z,         0, 1, Z);
    add(2'd0, 0, 0, Z,         0, Z,        0, 0, 0,   Z,         0, 1, Z);
    add(2'd0, 1, 1, 64'h5555,  0, Z,        0, 0, 0,   Z,         0, 1, Z);
    add(2'd0, 1, 0, Z,         0, Z,        0, 0, 0,   64'hBBBB,  0, 1, Z);
    add(2'd3, 1, 1, 64'h7,     0, Z,        0, 0, 0,   Z,         0, 1, Z);
    add(2'd3, 1, 0, Z,         0, Z,        0, 0, 0,   Z,         0, 1, Z);
    add(2'd1, 1, 1, 64'h1,     0, Z,        0, 0, 0,   Z,         0, 1, Z);
    add(2'd1, 1, 0, Z,         0, Z,        0, 0, 0,   Z,         0, 1, Z);

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i]);
      @(negedge clk);
      chk($sformatf("v%0d d_out", i), d_out, vq[i].e_dout);
      chk($sformatf("v%0d net_so", i), 64'(net_so), 64'(vq[i].e_so));
      chk($sformatf("v%0d net_ri", i), 64'(net_ri), 64'(vq[i].e_ri));
      chk($sformatf("v%0d net_do", i), net_do, vq[i].e_do);
      @(posedge clk); #1;
    end

    // Mid-operation reset: fill both buffers, then pulse reset between edges.
    addr = 2'd2; nicEn = 1'b1; nicWrEn = 1'b1; d_in = PB;
    net_si = 1'b1; net_di = 64'hC0FFEE; net_ro = 1'b0; net_polarity = 1'b0;
    out_q.push_back(PB);
    @(posedge clk); #1;
    addr = 2'd1; nicWrEn = 1'b0; net_si = 1'b0;
    @(negedge clk);
    chk("mid_in_full", d_out, 64'd1);
    chk("mid_ri_low", 64'(net_ri), Z);
    chk("mid_do_full", net_do, PB);
    #1;
    reset = 1'b0;
    net_ro = 1'b1; net_polarity = 1'b1;
    out_q.delete();
    #1;
    chk("mid_rst_in_stat", d_out, Z);
    chk("mid_rst_ri", 64'(net_ri), 64'd1);
    chk("mid_rst_so", 64'(net_so), Z);
    chk("mid_rst_do", net_do, Z);
    addr = 2'd3;
    #1;
    chk("mid_rst_out_stat", d_out, Z);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_out_stat", d_out, Z);
    chk("post_rst_so", 64'(net_so), Z);
    chk("post_rst_ri", 64'(net_ri), 64'd1);
    @(posedge clk); #1;
    addr = 2'd1;
    @(negedge clk);
    chk("post_rst_in_stat", d_out, Z);
    @(posedge clk); #1;
    nicEn = 1'b0; net_ro = 1'b0;

    chk("sb_empty", 64'(out_q.size()), Z);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
